// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared types and sizing helpers for the pipelined Kogge-Stone adder
// Purpose: propagate/generate pair type and the level/stage count functions.
// Ports: none (package).
package ks_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Number of Kogge-Stone prefix levels for a given operand width.
  function automatic int ks_levels(input int w);
    return $clog2(w);
  endfunction

  // Number of prefix pipeline stages when lps levels share one register stage.
  function automatic int ks_stages(input int w, input int lps);
    return (ks_levels(w) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// rtl/ks_prefix_level.sv - one combinational Kogge-Stone prefix level
// Purpose: combine each bit i with bit i-DIST; bits below DIST pass through.
// Ports:
//   pg_in   in  WIDTH x pg_t  propagate/generate pairs entering the level
//   pg_out  out WIDTH x pg_t  propagate/generate pairs leaving the level
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  pg_t [WIDTH-1:0] pg_in,
  output pg_t [WIDTH-1:0] pg_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_comb
      assign pg_out[i].g = pg_in[i].g | (pg_in[i].p & pg_in[i-DIST].g);
      assign pg_out[i].p = pg_in[i].p & pg_in[i-DIST].p;
    end else begin : g_pass
      assign pg_out[i] = pg_in[i];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone adder/subtractor with valid/ready handshake
// Purpose: A + B + cin or A - B, with carry-out, signed overflow and zero flags.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand beat handshake
//   in_a, in_b             operands (WIDTH)
//   in_cin                 carry-in, add mode only
//   in_sub                 1 = A - B, 0 = A + B + cin
//   out_valid/out_ready    result beat handshake
//   out_sum                result (WIDTH)
//   out_cout               carry-out (subtract: 1 = no borrow)
//   out_ovf                signed two's-complement overflow
//   out_zero               out_sum == 0
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int N   = ks_levels(WIDTH);
  localparam int K   = ks_stages(WIDTH, LPS);
  localparam int MSB = WIDTH - 1;

  // Global stall: the whole pipeline moves only when the output slot is free
  // or being drained this cycle. in_ready is deliberately combinational.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Preprocess: subtract is A + ~B + 1, so cin is forced to 1 in that mode.
  logic [WIDTH-1:0] b_e;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  logic             c_e;
  pg_t  [WIDTH-1:0] pg0;

  assign b_e = in_sub ? ~in_b : in_b;
  assign c_e = in_sub | in_cin;
  assign p0  = in_a ^ b_e;
  assign g0  = in_a & b_e;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pg0
    assign pg0[i] = {p0[i], g0[i]};
  end

  // Stage registers S0..SK; S0 holds the preprocessed pairs, Sj the pairs
  // after j groups of LPS prefix levels.
  logic [WIDTH-1:0] st_p0 [0:K];
  pg_t  [WIDTH-1:0] st_pg [0:K];
  logic             st_ce [0:K];
  logic             st_am [0:K];
  logic             st_bm [0:K];
  logic             st_v  [0:K];
  pg_t  [WIDTH-1:0] grp_out [0:K-1];

  // Prefix levels: the first level of each group reads a stage register,
  // the rest chain combinationally from the previous level.
  for (genvar k = 0; k < N; k++) begin : g_lvl
    pg_t [WIDTH-1:0] lin;
    pg_t [WIDTH-1:0] lout;
    if (k % LPS == 0) begin : g_head
      assign lin = st_pg[k/LPS];
    end else begin : g_chain
      assign lin = g_lvl[k-1].lout;
    end
    ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_level (
      .pg_in  (lin),
      .pg_out (lout)
    );
  end

  // The last group may hold fewer than LPS levels when LPS does not divide N.
  for (genvar j = 0; j < K; j++) begin : g_grp
    localparam int LAST = (((j + 1) * LPS < N) ? (j + 1) * LPS : N) - 1;
    assign grp_out[j] = g_lvl[LAST].lout;
  end

  // Sum and flag generation from the final prefix stage.
  logic [WIDTH-1:0] gk;
  logic [WIDTH-1:0] pk;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always_comb begin
    gk = '0;
    pk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gk[i] = st_pg[K][i].g;
      pk[i] = st_pg[K][i].p;
    end
    carry = {gk[WIDTH-2:0] | (pk[WIDTH-2:0] & {(WIDTH-1){st_ce[K]}}), st_ce[K]};
    cout  = gk[MSB] | (pk[MSB] & st_ce[K]);
    sum   = st_p0[K] ^ carry;
    ovf   = (st_am[K] == st_bm[K]) & (sum[MSB] != st_am[K]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= K; j++) begin
        st_p0[j] <= '0;
        st_pg[j] <= '0;
        st_ce[j] <= 1'b0;
        st_am[j] <= 1'b0;
        st_bm[j] <= 1'b0;
        st_v[j]  <= 1'b0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (en) begin
      st_v[0]  <= in_valid;
      st_p0[0] <= p0;
      st_pg[0] <= pg0;
      st_ce[0] <= c_e;
      st_am[0] <= in_a[MSB];
      st_bm[0] <= b_e[MSB];
      for (int j = 1; j <= K; j++) begin
        st_v[j]  <= st_v[j-1];
        st_p0[j] <= st_p0[j-1];
        st_pg[j] <= grp_out[j-1];
        st_ce[j] <= st_ce[j-1];
        st_am[j] <= st_am[j-1];
        st_bm[j] <= st_bm[j-1];
      end
      out_valid <= st_v[K];
      out_sum   <= sum;
      out_cout  <= cout;
      out_ovf   <= ovf;
      out_zero  <= ~|sum;
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb/tb_ks_adder_pipe.sv - scoreboard bench for ks_adder_pipe (16/2 and 8/1 configurations)
`timescale 1ns/1ps
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v16, ir16, cin16, sub16, ov16, or16, co16, of16, z16;
  logic [15:0] a16, b16, s16;
  logic        v8, ir8, cin8, sub8, ov8, or8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;

  ks_adder_pipe #(.WIDTH(16), .LPS(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16),
    .in_a(a16), .in_b(b16), .in_cin(cin16), .in_sub(sub16),
    .out_valid(ov16), .out_ready(or16), .out_sum(s16),
    .out_cout(co16), .out_ovf(of16), .out_zero(z16)
  );

  ks_adder_pipe #(.WIDTH(8), .LPS(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
    .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8),
    .out_valid(ov8), .out_ready(or8), .out_sum(s8),
    .out_cout(co8), .out_ovf(of8), .out_zero(z8)
  );

  typedef struct {
    int sum;
    bit cout;
    bit ovf;
    bit zero;
  } res_t;

  res_t q16[$];
  res_t q8[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out16  = 0;
  int   n_out8   = 0;
  bit   rnd8     = 1'b0;
  bit   tog16    = 1'b0;

  // Arithmetic reference: integer add/subtract with range checks.
  function automatic res_t model(input int w, input int a, input int b, input bit cin, input bit sub);
    res_t r;
    int m, h, sa, sb, full, sfull;
    m  = 1 << w;
    h  = m / 2;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    if (sub) begin
      full   = a - b;
      sfull  = sa - sb;
      r.cout = (a >= b);
    end else begin
      full   = a + b + int'(cin);
      sfull  = sa + sb + int'(cin);
      r.cout = (full >= m);
    end
    r.sum  = (full + m) % m;
    r.ovf  = (sfull < -h) || (sfull >= h);
    r.zero = (r.sum == 0);
    return r;
  endfunction

  function automatic res_t lit(input int sum, input bit cout, input bit ovf, input bit zero);
    res_t r;
    r.sum = sum; r.cout = cout; r.ovf = ovf; r.zero = zero;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Drivers: called at posedge+1, return at posedge+1 after the accept edge.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub, input res_t e);
    int tries;
    bit acc;
    tries = 0; acc = 1'b0;
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = ir16;
      if (acc) q16.push_back(e);
      @(posedge clk); #1;
      tries++;
      if (!acc && tries > 200) begin bound_fail("send16"); acc = 1'b1; end
    end
    v16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int tries;
    bit acc;
    tries = 0; acc = 1'b0;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; v8 = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = ir8;
      if (acc) q8.push_back(model(8, int'(a), int'(b), cin, sub));
      @(posedge clk); #1;
      tries++;
      if (!acc && tries > 200) begin bound_fail("send8"); acc = 1'b1; end
    end
    v8 = 1'b0;
  endtask

  task automatic drain16();
    int c;
    c = 0;
    while (q16.size() != 0 && c < 2000) begin @(posedge clk); c++; end
    #1;
    if (q16.size() != 0) bound_fail("drain16");
  endtask

  task automatic drain8();
    int c;
    c = 0;
    while (q8.size() != 0 && c < 2000) begin @(posedge clk); c++; end
    #1;
    if (q8.size() != 0) bound_fail("drain8");
  endtask

  // One isolated beat on an idle pipeline; counts edges from the accept edge
  // (counted as 1) until out_valid is seen.
  task automatic latency16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub, input res_t e);
    int cyc;
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1;
    q16.push_back(e);
    @(posedge clk); cyc = 1; #1; v16 = 1'b0;
    while (cyc < 30) begin
      @(negedge clk);
      if (ov16) break;
      @(posedge clk); cyc++;
    end
    check("latency16", cyc, 4);
    @(posedge clk); #1;
  endtask

  task automatic latency8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int cyc;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; v8 = 1'b1;
    q8.push_back(model(8, int'(a), int'(b), cin, sub));
    @(posedge clk); cyc = 1; #1; v8 = 1'b0;
    while (cyc < 30) begin
      @(negedge clk);
      if (ov8) break;
      @(posedge clk); cyc++;
    end
    check("latency8", cyc, 5);
    @(posedge clk); #1;
  endtask

  // Monitors: pop and compare on every output transfer; also check the
  // ready rule and that a stalled output holds still.
  initial begin : mon16
    res_t        e;
    bit          hold;
    logic [19:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        check("in_ready16", ir16, !ov16 || or16);
        if (hold) check("hold16", {ov16, s16, co16, of16, z16}, held);
        if (ov16 && or16) begin
          if (q16.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected16: got sum %0h, expected no beat", s16);
          end else begin
            e = q16.pop_front();
            check("result16", {s16, co16, of16, z16}, {e.sum[15:0], e.cout, e.ovf, e.zero});
          end
          n_out16++;
        end
        hold = ov16 && !or16;
        held = {ov16, s16, co16, of16, z16};
      end
    end
  end

  initial begin : mon8
    res_t        e;
    bit          hold;
    logic [11:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        check("in_ready8", ir8, !ov8 || or8);
        if (hold) check("hold8", {ov8, s8, co8, of8, z8}, held);
        if (ov8 && or8) begin
          if (q8.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected8: got sum %0h, expected no beat", s8);
          end else begin
            e = q8.pop_front();
            check("result8", {s8, co8, of8, z8}, {e.sum[7:0], e.cout, e.ovf, e.zero});
          end
          n_out8++;
        end
        hold = ov8 && !or8;
        held = {ov8, s8, co8, of8, z8};
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rnd8) or8 = 1'($urandom_range(0, 1));
      if (tog16) or16 = ~or16;
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    rst_n = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    v8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; or8  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid16", ov16, 0);
    check("reset out_flags16", {s16, co16, of16, z16}, 0);
    check("reset in_ready16", ir16, 1);
    check("reset out_valid8", ov8, 0);
    check("reset in_ready8", ir8, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases with hand-computed expectations.
    latency16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lit(16'h0000, 1, 0, 1));
    send16(16'h8000, 16'h0001, 1'b0, 1'b1, lit(16'h7FFF, 1, 1, 0));
    send16(16'h7FFF, 16'h0000, 1'b1, 1'b0, lit(16'h8000, 0, 1, 0));
    send16(16'h0005, 16'h0005, 1'b1, 1'b1, lit(16'h0000, 1, 0, 1));
    send16(16'h0003, 16'h0005, 1'b0, 1'b1, lit(16'hFFFE, 0, 0, 0));
    drain16();

    // Backpressure: 8 beats, out_ready low for 3 cycles after the 2nd output.
    base = n_out16;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send16(16'(i), 16'(16'h0100 * i), 1'b0, 1'b0, model(16, i, 256 * i, 1'b0, 1'b0));
      end
      begin
        int c;
        c = 0;
        while (n_out16 < base + 2 && c < 100) begin @(negedge clk); c++; end
        if (n_out16 < base + 2) bound_fail("bp_wait");
        @(posedge clk); #1;
        or16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        or16 = 1'b1;
      end
    join
    drain16();
    check("bp_count", n_out16 - base, 8);

    // Random stream with out_ready toggling every cycle.
    tog16 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send16(ra, rb, rc, rs, model(16, int'(ra), int'(rb), rc, rs));
    end
    drain16();
    tog16 = 1'b0;
    @(posedge clk); #1;
    or16 = 1'b1;

    // Reset with beats in flight.
    for (int i = 1; i <= 4; i++) begin
      a16 = 16'(i); b16 = 16'(i); cin16 = 1'b0; sub16 = 1'b0; v16 = 1'b1;
      @(posedge clk); #1;
    end
    v16 = 1'b0;
    check("pre-reset out_valid16", ov16, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-reset out_valid16", ov16, 0);
    check("mid-reset out_flags16", {s16, co16, of16, z16}, 0);
    check("mid-reset in_ready16", ir16, 1);
    q16.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post-reset idle16", ov16, 0);
    end
    @(posedge clk); #1;
    latency16(16'h1234, 16'h0FFF, 1'b1, 1'b0, model(16, 16'h1234, 16'h0FFF, 1'b1, 1'b0));
    drain16();

    // WIDTH=8, LPS=1: latency, then a wide sweep with random out_ready.
    latency8(8'hFF, 8'h01, 1'b0, 1'b0);
    drain8();
    rnd8 = 1'b1;
    for (int m = 0; m < 3; m++) begin
      for (int a = 0; a < 256; a++) begin
        logic [7:0] bv [8];
        bv[0] = 8'h00; bv[1] = 8'h01; bv[2] = 8'h7F; bv[3] = 8'h80;
        bv[4] = 8'hFF; bv[5] = 8'(a); bv[6] = ~8'(a); bv[7] = 8'($urandom);
        for (int j = 0; j < 8; j++)
          send8(8'(a), bv[j], (m == 1), (m == 2));
      end
    end
    drain8();
    rnd8 = 1'b0;
    @(posedge clk); #1;
    or8 = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
